fifo_thresh: RTL and testbench
==============================

FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 SHALL have parameter SIZE, default 8: storage depth in words, any integer >= 2 (non-power-of-2 allowed).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width in bits, >= 1.
REQ-003 SHALL have parameter AFULL_LEVEL, default SIZE-1: almost_full asserts when count >= this value.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 1: almost_empty asserts when count <= this value.
REQ-005 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port ce  input  1: clock enable; when 0, all inputs are ignored and all state holds.
REQ-008 SHALL have port flush  input  1: synchronous clear of contents and sticky flags.
REQ-009 SHALL have ports wr_en  input  1 and wr_data  input  DATA_WIDTH: write request and data.
REQ-010 SHALL have ports rd_en  input  1, rd_data  output  DATA_WIDTH and rd_valid  output  1: read request, data and data-valid.
REQ-011 SHALL have outputs empty, full, almost_full, almost_empty, overflow, underflow  (each 1): status flags.
REQ-012 SHALL have output count  $clog2(SIZE+1) bits: number of stored words.

Function
REQ-013 SHALL accept a write when ce=1, flush=0, wr_en=1, and either full=0 or a read is accepted in the same cycle.
REQ-014 SHALL accept a read when ce=1, flush=0, rd_en=1 and empty=0; a read on empty is dropped even if a write is accepted in the same cycle.
REQ-015 SHALL keep count unchanged on simultaneous accepted write and read, including at full.
REQ-016 SHALL wrap the write and read pointers from SIZE-1 to 0.
REQ-017 SHALL drive empty=(count==0), full=(count==SIZE) and the almost flags per REQ-003/004 as registered outputs consistent with count.
REQ-018 SHALL set overflow (sticky) on a rejected write and underflow (sticky) on a rejected read; only flush or reset clears them.
REQ-019 SHALL give flush priority over wr_en/rd_en: pointers, count and sticky flags are zeroed and rd_valid deasserts the next cycle; flush is ignored when ce=0.
REQ-020 SHALL leave storage contents unreset; only pointers and flags are reset.

Reset
REQ-021 SHALL on rst=0, immediately and independent of clk and ce, force count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0 and pointers=0.
REQ-022 SHALL discard all contents when reset is asserted mid-operation; the first accepted write after reset is the first word read.

Configuration
REQ-023 SHALL, when macro FIFO_THRESH_FWFT_EN is defined, operate first-word-fall-through: rd_data shows the head word whenever empty=0, rd_valid=!empty, and an accepted read pops the head.
REQ-024 SHALL, when FIFO_THRESH_FWFT_EN is undefined, register read data: rd_data/rd_valid update one cycle after an accepted read, rd_valid pulses for one cycle per read, and rd_data holds its last value otherwise.

Structure
REQ-025 SHALL place the count-width function and the flag-index localparams in package fifo_thresh_pkg.
REQ-026 SHALL use one sub-module, fifo_thresh_ram (simple dual-port, 1 write port, 1 read port, no reset), for storage.

Verification
REQ-027 SHALL test this case: SIZE=8, DATA_WIDTH=4; write 0..8 on 9 cycles -> the 9th write is rejected, full=1, count=8, overflow=1 sticky.
REQ-028 SHALL test this case: then 9 reads -> data 0..7 in order, 9th read rejected, empty=1, underflow=1; no-FWFT: rd_valid 8 pulses, each 1 cycle after rd_en.
REQ-029 SHALL test this case: at full, write 0xA and read together -> head popped, 0xA stored, count stays 8, overflow unchanged.
REQ-030 SHALL test this case: SIZE=5, push/pop 12 words -> order preserved across pointer wrap at index 4.
REQ-031 SHALL test this case: with 3 words stored, set ce=0 for 4 cycles with wr_en=rd_en=flush=1 -> no change; then flush with ce=1 -> count=0, flags cleared.
REQ-032 SHALL test this case: drop rst mid-cycle with count=5 -> outputs take reset values before the next clk edge; with AFULL_LEVEL=6, AEMPTY_LEVEL=2, check flag edges at counts 2/3 and 5/6.

Source files
------------

// File: rtl/fifo_thresh_pkg.sv
// fifo_thresh_pkg: width helpers and status-flag bit positions shared by the FIFO.
`default_nettype none

package fifo_thresh_pkg;

    localparam int FLAG_EMPTY  = 0;
    localparam int FLAG_FULL   = 1;
    localparam int FLAG_AEMPTY = 2;
    localparam int FLAG_AFULL  = 3;
    localparam int FLAG_OVF    = 4;
    localparam int FLAG_UNF    = 5;
    localparam int NUM_FLAGS   = 6;

    // Count must represent 0..SIZE inclusive.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

    function automatic int ptr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_thresh_ram.sv
// fifo_thresh_ram: simple dual-port storage, one synchronous write port, one asynchronous read port, no reset.
`default_nettype none

module fifo_thresh_ram
    import fifo_thresh_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous FIFO with threshold flags, sticky overflow/underflow and flush.
// Define FIFO_THRESH_FWFT_EN for first-word-fall-through reads; otherwise read data is registered.
`default_nettype none

module fifo_thresh
    import fifo_thresh_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_LEVEL  = SIZE - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic [cnt_width(SIZE)-1:0] count
);

    localparam int AW = ptr_width(SIZE);
    localparam int CW = cnt_width(SIZE);
    localparam logic [NUM_FLAGS-1:0] RST_FLAGS =
        NUM_FLAGS'((1 << FLAG_EMPTY) | (1 << FLAG_AEMPTY));

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [NUM_FLAGS-1:0]  flags;
    logic [NUM_FLAGS-1:0]  flags_nxt;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_acc;
    logic                  rd_acc;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(SIZE - 1)) ? '0 : p + AW'(1);
    endfunction

    // A write into a full FIFO is still accepted when a read frees a slot this cycle.
    assign rd_acc = ce & ~flush & rd_en & ~flags[FLAG_EMPTY];
    assign wr_acc = ce & ~flush & wr_en & (~flags[FLAG_FULL] | rd_acc);

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
        flags_nxt              = '0;
        flags_nxt[FLAG_EMPTY]  = (count_nxt == '0);
        flags_nxt[FLAG_FULL]   = (count_nxt == CW'(SIZE));
        flags_nxt[FLAG_AFULL]  = (count_nxt >= CW'(AFULL_LEVEL));
        flags_nxt[FLAG_AEMPTY] = (count_nxt <= CW'(AEMPTY_LEVEL));
        flags_nxt[FLAG_OVF]    = ~flush & (flags[FLAG_OVF] | (wr_en & ~wr_acc));
        flags_nxt[FLAG_UNF]    = ~flush & (flags[FLAG_UNF] | (rd_en & ~rd_acc));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= RST_FLAGS;
        end else if (ce) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
                if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            flags <= flags_nxt;
        end
    end

    assign empty        = flags[FLAG_EMPTY];
    assign full         = flags[FLAG_FULL];
    assign almost_full  = flags[FLAG_AFULL];
    assign almost_empty = flags[FLAG_AEMPTY];
    assign overflow     = flags[FLAG_OVF];
    assign underflow    = flags[FLAG_UNF];

    fifo_thresh_ram #(
        .DEPTH (SIZE),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

`ifdef FIFO_THRESH_FWFT_EN
    // Head word is visible combinationally; masked to zero so reset forces rd_data low at once.
    assign rd_valid = ~flags[FLAG_EMPTY];
    assign rd_data  = flags[FLAG_EMPTY] ? '0 : ram_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (ce) begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= ram_q;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: queue-based reference model and scoreboard for fifo_thresh (SIZE=8 and SIZE=5 instances).
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_thresh;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0] wr_data = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Both instances see the same stimulus; each keeps its own model and monitor.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int SZ = (g == 0) ? 8 : 5;
        localparam int AF = (g == 0) ? 6 : SZ - 1;
        localparam int AE = (g == 0) ? 2 : 1;
        localparam int CW = $clog2(SZ + 1);

        logic [3:0]    rd_data;
        logic          rd_valid, empty, full, almost_full, almost_empty, overflow, underflow;
        logic [CW-1:0] count;

        fifo_thresh #(
            .SIZE(SZ), .DATA_WIDTH(4), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
        ) u_dut (
            .clk(clk), .rst(rst), .ce(ce), .flush(flush),
            .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
            .rd_data(rd_data), .rd_valid(rd_valid),
            .empty(empty), .full(full), .almost_full(almost_full),
            .almost_empty(almost_empty), .overflow(overflow),
            .underflow(underflow), .count(count)
        );

        logic [3:0] mq[$];
        logic [3:0] eq[$];
        bit         movf = 0, munf = 0, last_ce = 0;

        initial forever begin : p_model
            bit ra, wa;
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete(); eq.delete();
                movf = 0; munf = 0; last_ce = 0;
            end else begin
                last_ce = ce;
                if (ce && flush) begin
                    mq.delete(); movf = 0; munf = 0;
                end else if (ce) begin
                    ra = rd_en && (mq.size() > 0);
                    wa = wr_en && ((mq.size() < SZ) || ra);
                    if (rd_en && !ra) munf = 1;
                    if (wr_en && !wa) movf = 1;
                    if (ra) eq.push_back(mq.pop_front());
                    if (wa) mq.push_back(wr_data);
                end
            end
        end

        initial forever begin : p_monitor
            int n;
            @(negedge clk);
            n = mq.size();
            check($sformatf("i%0d count", g), count, n);
            check($sformatf("i%0d empty", g), empty, n == 0);
            check($sformatf("i%0d full", g), full, n == SZ);
            check($sformatf("i%0d almost_full", g), almost_full, n >= AF);
            check($sformatf("i%0d almost_empty", g), almost_empty, n <= AE);
            check($sformatf("i%0d overflow", g), overflow, movf);
            check($sformatf("i%0d underflow", g), underflow, munf);
`ifdef FIFO_THRESH_FWFT_EN
            check($sformatf("i%0d rd_valid", g), rd_valid, n != 0);
            if (n != 0) check($sformatf("i%0d rd_data", g), rd_data, mq[0]);
            eq.delete();
`else
            // With ce low the output register is frozen, so only edges with ce high produce a pulse.
            if (last_ce) begin
                check($sformatf("i%0d rd_valid", g), rd_valid, eq.size() != 0);
                if (rd_valid && eq.size() != 0)
                    check($sformatf("i%0d rd_data", g), rd_data, eq[0]);
                eq.delete();
            end
`endif
        end
    end

    task automatic cyc(input logic c, input logic f, input logic w, input logic [3:0] d, input logic r);
        ce = c; flush = f; wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [6:0] ae_tab, af_tab;
        int       sticky;
        ae_tab = 7'b0000011;
        af_tab = 7'b1100000;

        repeat (3) @(posedge clk);
        #1;
        check("reset count", g_inst[0].count, 0);
        check("reset empty", g_inst[0].empty, 1);
        check("reset almost_empty", g_inst[0].almost_empty, 1);
        check("reset full", g_inst[0].full, 0);
        check("reset rd_valid", g_inst[0].rd_valid, 0);
        check("reset rd_data", g_inst[0].rd_data, 0);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 4'(i), 0);
        check("fill full", g_inst[0].full, 1);
        check("fill count", g_inst[0].count, 8);
        check("fill overflow", g_inst[0].overflow, 1);
        cyc(1, 0, 0, 0, 0);
        check("overflow sticky", g_inst[0].overflow, 1);

        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 0, 0, 1);
`ifndef FIFO_THRESH_FWFT_EN
            check("drain rd_valid pulse", g_inst[0].rd_valid, (i < 8) ? 1 : 0);
            if (i < 8) check("drain rd_data", g_inst[0].rd_data, i);
`endif
        end
        check("drain empty", g_inst[0].empty, 1);
        check("drain underflow", g_inst[0].underflow, 1);
        cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 4'(i + 3), 0);
        sticky = int'(g_inst[0].overflow);
        cyc(1, 0, 1, 4'hA, 1);
        check("full rw count", g_inst[0].count, 8);
        check("full rw overflow", g_inst[0].overflow, sticky);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);

        cyc(1, 1, 0, 0, 0);
        check("flush count", g_inst[0].count, 0);
        check("flush overflow", g_inst[0].overflow, 0);
        check("flush underflow", g_inst[0].underflow, 0);

        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'(15 - i), 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 1, 4'($urandom), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'(i + 7), 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4'hF, 1);
        check("ce0 count i0", g_inst[0].count, 3);
        check("ce0 count i1", g_inst[1].count, 3);
        check("ce0 overflow", g_inst[0].overflow, 0);
        cyc(1, 1, 1, 4'hF, 1);
        check("ce flush count", g_inst[0].count, 0);
        check("ce flush empty", g_inst[0].empty, 1);
        cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 1, 4'(i), 0);
            check($sformatf("edge almost_empty n=%0d", i + 1), g_inst[0].almost_empty, ae_tab[i]);
            check($sformatf("edge almost_full n=%0d", i + 1), g_inst[0].almost_full, af_tab[i]);
        end
        cyc(1, 1, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            cyc(($urandom % 10) != 0, ($urandom % 40) == 0,
                ($urandom % 100) < ((i < 250) ? 65 : 35), 4'($urandom),
                ($urandom % 100) < ((i < 250) ? 35 : 65));
        end

        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 4'(i + 1), 0);
        cyc(1, 0, 0, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        check("async count", g_inst[0].count, 0);
        check("async empty", g_inst[0].empty, 1);
        check("async almost_empty", g_inst[0].almost_empty, 1);
        check("async full i1", g_inst[1].full, 0);
        check("async rd_valid", g_inst[0].rd_valid, 0);
        check("async rd_data", g_inst[0].rd_data, 0);
        ce = 0; flush = 0; wr_en = 0; rd_en = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 0, 1, 4'h9, 0);
        cyc(1, 0, 1, 4'h4, 0);
        cyc(1, 0, 0, 0, 1);
`ifndef FIFO_THRESH_FWFT_EN
        check("post-reset first word", g_inst[0].rd_data, 9);
`endif
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
